// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Destination-register scheduler for the EX/MEM/WB write pipeline.
//   Tracks {rd, we, ld} for each in-flight slot. From that state it drives the
//   load-use stall, bubble insertion, branch flush and operand forwarding selects.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   id_*              : decode-stage instruction fields (valid, sources, rd, kind)
//   branch_taken      : redirect, squashes the decode instruction
//   freeze            : global hold; no slot or counter moves
//   stall             : hold PC and IF/ID this cycle (combinational)
//   ex_rd/mem_rd/wb_rd: rd of each slot, 0 when the slot does not write
//   wb_we             : register file write enable
//   fwd_a/fwd_b       : 00 regfile, 01 EX, 10 MEM, 11 WB (combinational)
//   stall_count       : saturating count of stall cycles
module hazard_control_unit #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             branch_taken,
  input  logic             freeze,
  output logic             stall,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_we,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_m1, ex_m2;
  logic mem_m1, mem_m2;
  logic wb_m1, wb_m2;
  logic id_we;
  logic cnt_sat;

  // Forwarding priority: youngest non-load producer wins; a load in EX is
  // skipped because the stall covers it.
  function automatic logic [1:0] sel_fwd(input logic ex_m, input logic ex_ld,
                                         input logic mem_m, input logic wb_m);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_m && !ex_ld) begin
      sel = FWD_EX;
    end else if (mem_m) begin
      sel = FWD_MEM;
    end else if (wb_m) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // A write to x0 never creates a hazard, a forward, or a register file write.
  assign id_we = id_reg_write & (id_rd != '0);

  // Source-vs-slot matches, gated by operand use and decode validity.
  always_comb begin
    ex_m1  = id_valid & id_rs1_used & ex_q.we  & (ex_q.rd  == id_rs1);
    ex_m2  = id_valid & id_rs2_used & ex_q.we  & (ex_q.rd  == id_rs2);
    mem_m1 = id_valid & id_rs1_used & mem_q.we & (mem_q.rd == id_rs1);
    mem_m2 = id_valid & id_rs2_used & mem_q.we & (mem_q.rd == id_rs2);
    wb_m1  = id_valid & id_rs1_used & wb_q.we  & (wb_q.rd  == id_rs1);
    wb_m2  = id_valid & id_rs2_used & wb_q.we  & (wb_q.rd  == id_rs2);
  end

  // Load-use stall; a taken branch squashes decode so the stall is moot.
  assign stall = (ex_m1 | ex_m2) & ex_q.ld & ~branch_taken;

  assign fwd_a = sel_fwd(ex_m1, ex_q.ld, mem_m1, wb_m1);
  assign fwd_b = sel_fwd(ex_m2, ex_q.ld, mem_m2, wb_m2);

  assign cnt_sat = (cnt_q == {CNT_W{1'b1}});

  // Slot advance and stall counter next state.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (stall || branch_taken || !id_valid) begin
        ex_d = BUBBLE;
      end else begin
        ex_d.rd = id_rd;
        ex_d.we = id_we;
        ex_d.ld = id_is_load;
      end
      if (stall && !cnt_sat) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  // Slot outputs read 0 unless the slot actually writes.
  assign ex_rd       = ex_q.we  ? ex_q.rd  : '0;
  assign mem_rd      = mem_q.we ? mem_q.rd : '0;
  assign wb_rd       = wb_q.we  ? wb_q.rd  : '0;
  assign wb_we       = wb_q.we;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: a pipeline-of-instructions model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_hazard_control_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
  logic       branch_taken, freeze;

  logic        stall, wb_we;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  logic        stall_s, wb_we_s;
  logic [4:0]  ex_rd_s, mem_rd_s, wb_rd_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [3:0]  stall_count_s;

  hazard_control_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .freeze(freeze),
    .stall(stall), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .wb_we(wb_we), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  hazard_control_unit #(.REG_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .freeze(freeze),
    .stall(stall_s), .ex_rd(ex_rd_s), .mem_rd(mem_rd_s), .wb_rd(wb_rd_s),
    .wb_we(wb_we_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_count(stall_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
    logic       frz;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: instructions in flight, index 0 = youngest (EX). rd is 0 for
  // instructions that do not write a register.
  logic [4:0]  m_rd[3];
  logic        m_ld[3];
  int unsigned m_cnt, m_cnt_s;
  stim_t       cur;

  function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < 3; a++) begin
      m_rd[a] = 5'd0;
      m_ld[a] = 1'b0;
    end
    m_cnt   = 0;
    m_cnt_s = 0;
  endfunction

  // Source of an operand: walk oldest to youngest so the youngest producer
  // that can forward ends up selected; a load still in EX cannot forward.
  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic used, input logic valid);
    logic [1:0] f;
    f = 2'd0;
    if (valid && used) begin
      for (int a = 2; a >= 0; a--) begin
        if (m_rd[a] != 5'd0 && m_rd[a] == rs && !(a == 0 && m_ld[0])) f = 2'(a + 1);
      end
    end
    return f;
  endfunction

  function automatic logic m_stall(input stim_t s);
    logic hit;
    hit = (s.u1 && s.rs1 == m_rd[0]) || (s.u2 && s.rs2 == m_rd[0]);
    return s.valid && !s.br && m_ld[0] && (m_rd[0] != 5'd0) && hit;
  endfunction

  function automatic stim_t ins(input logic [4:0] rd, input logic rw, input logic ld,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.rd = rd; s.rw = rw; s.ld = ld;
    s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 249) == 0);
    s.valid = ($urandom_range(0, 99) < 85);
    s.rs1   = 5'($urandom_range(0, 7));
    s.u1    = ($urandom_range(0, 3) != 0);
    s.rs2   = 5'($urandom_range(0, 7));
    s.u2    = ($urandom_range(0, 3) != 0);
    s.rd    = 5'($urandom_range(0, 7));
    s.rw    = ($urandom_range(0, 4) != 0);
    s.ld    = ($urandom_range(0, 2) == 0);
    s.br    = ($urandom_range(0, 9) == 0);
    s.frz   = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Apply one cycle of inputs (just after a rising edge) and queue the prediction.
  task automatic drive(input stim_t s);
    exp_t e;
    cur          = s;
    rst_n        = !s.rst;
    id_valid     = s.valid;
    id_rs1       = s.rs1;
    id_rs2       = s.rs2;
    id_rs1_used  = s.u1;
    id_rs2_used  = s.u2;
    id_rd        = s.rd;
    id_reg_write = s.rw;
    id_is_load   = s.ld;
    branch_taken = s.br;
    freeze       = s.frz;
    if (s.rst) model_clear();
    e.stall  = m_stall(s);
    e.ex_rd  = m_rd[0];
    e.mem_rd = m_rd[1];
    e.wb_rd  = m_rd[2];
    e.wb_we  = (m_rd[2] != 5'd0);
    e.fa     = m_fwd(s.rs1, s.u1, s.valid);
    e.fb     = m_fwd(s.rs2, s.u2, s.valid);
    e.cnt    = 16'(m_cnt);
    e.cnt_s  = 4'(m_cnt_s);
    sb.push_back(e);
  endtask

  // Clock edge: retire the model one step, then move just past the edge.
  task automatic advance();
    logic st;
    @(posedge clk);
    if (!cur.rst && !cur.frz) begin
      st = m_stall(cur);
      if (st) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
      m_rd[2] = m_rd[1]; m_ld[2] = m_ld[1];
      m_rd[1] = m_rd[0]; m_ld[1] = m_ld[0];
      if (st || cur.br || !cur.valid) begin
        m_rd[0] = 5'd0;
        m_ld[0] = 1'b0;
      end else begin
        m_rd[0] = cur.rw ? cur.rd : 5'd0;
        m_ld[0] = cur.ld;
      end
    end
    #1;
  endtask

  task automatic step(input stim_t s);
    drive(s);
    advance();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step('0);
  endtask

  // Monitor: compare every queued prediction on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("ex_rd", 32'(ex_rd), 32'(e.ex_rd));
        chk("mem_rd", 32'(mem_rd), 32'(e.mem_rd));
        chk("wb_rd", 32'(wb_rd), 32'(e.wb_rd));
        chk("wb_we", 32'(wb_we), 32'(e.wb_we));
        chk("fwd_a", 32'(fwd_a), 32'(e.fa));
        chk("fwd_b", 32'(fwd_b), 32'(e.fb));
        chk("stall_count", 32'(stall_count), 32'(e.cnt));
        chk("sat_count", 32'(stall_count_s), 32'(e.cnt_s));
        chk("sat_outputs",
            32'({stall_s, ex_rd_s, mem_rd_s, wb_rd_s, wb_we_s, fwd_a_s, fwd_b_s}),
            32'({e.stall, e.ex_rd, e.mem_rd, e.wb_rd, e.wb_we, e.fa, e.fb}));
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_write = 1'b0; id_is_load = 1'b0;
    branch_taken = 1'b0; freeze = 1'b0;
    cur = '0;
    model_clear();
    @(posedge clk);
    #1;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      s = rand_stim();
      s.rst = 1'b1;
      drive(s);
      #1;
      chk("rst_outputs_zero",
          32'({stall, ex_rd, mem_rd, wb_rd, wb_we, fwd_a, fwd_b, stall_count}), 32'd0);
      advance();
    end

    // First instruction after reset walks EX -> MEM -> WB.
    step(ins(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    drive('0); #1; chk("first_ex_rd", 32'(ex_rd), 32'd5); advance();
    drive('0); #1; chk("first_mem_rd", 32'(mem_rd), 32'd5); advance();
    drive('0); #1; chk("first_wb", 32'({wb_rd, wb_we}), 32'({5'd5, 1'b1})); advance();
    drain();

    // ALU forwarding at distances 1, 2 and 3.
    for (int d = 1; d <= 3; d++) begin
      step(ins(5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1));
      for (int k = 1; k < d; k++) step(ins(5'(8 + k), 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1));
      drive(ins(5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1));
      #1;
      chk("alu_fwd_a", 32'(fwd_a), 32'(d));
      chk("alu_fwd_b", 32'(fwd_b), 32'(d));
      chk("alu_no_stall", 32'(stall), 32'd0);
      advance();
      drain();
    end

    // Load-use: one stall, bubble, then forward from MEM.
    step(ins(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    drive(ins(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1));
    #1; chk("lu_stall", 32'(stall), 32'd1); advance();
    drive(ins(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1));
    #1;
    chk("lu_bubble", 32'(ex_rd), 32'd0);
    chk("lu_stall_drop", 32'(stall), 32'd0);
    chk("lu_fwd_mem", 32'(fwd_a), 32'd2);
    chk("lu_count", 32'(stall_count), 32'd1);
    advance();
    drain();

    // x0 destination never hazards, forwards or writes back.
    step(ins(5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    drive(ins(5'd11, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1));
    #1;
    chk("x0_ex_rd", 32'(ex_rd), 32'd0);
    chk("x0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    advance();
    step('0);
    drive('0); #1; chk("x0_wb_we", 32'(wb_we), 32'd0); advance();
    drain();

    // Branch flush beats load-use.
    step(ins(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    s = ins(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1);
    s.br = 1'b1;
    drive(s); #1; chk("flush_no_stall", 32'(stall), 32'd0); advance();
    drive('0);
    #1;
    chk("flush_bubble", 32'(ex_rd), 32'd0);
    chk("flush_count", 32'(stall_count), 32'd1);
    advance();
    drain();

    // Freeze during load-use: stall held, nothing moves.
    step(ins(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      s = ins(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1);
      s.frz = 1'b1;
      drive(s);
      #1;
      chk("frz_stall", 32'(stall), 32'd1);
      chk("frz_slots", 32'({ex_rd, mem_rd}), 32'({5'd7, 5'd0}));
      chk("frz_count", 32'(stall_count), 32'd1);
      advance();
    end
    step(ins(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1));
    drive(ins(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1));
    #1;
    chk("unfrz_shift", 32'({ex_rd, mem_rd, 1'b0, stall}), 32'({5'd0, 5'd7, 2'b00}));
    chk("unfrz_count", 32'(stall_count), 32'd2);
    advance();
    drain();

    // Repeated load-use pairs saturate the narrow counter.
    for (int i = 0; i < 20; i++) begin
      step(ins(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
      step(ins(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1));
      step(ins(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1));
    end
    drive('0);
    #1;
    chk("sat_hold", 32'(stall_count_s), 32'hF);
    chk("wide_count", 32'(stall_count), 32'd22);
    advance();

    // Randomized traffic, including occasional mid-run resets.
    for (int i = 0; i < 1500; i++) step(rand_stim());
    step('0);

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
